// File: rtl/gsim_result_collector.sv
// Gauss-Seidel result collector: reorders stride-4 solver frames into natural order through a ping-pong bank pair.
// Optional build macro GSIM_COLLECT_ROUND_EN selects round-half-up instead of truncation on the Q16.16 conversion.
module gsim_result_collector #(
    parameter int OUT_W    = 16,
    parameter int OUT_FRAC = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [3:0]       out_index,
    output logic             out_last,
    output logic             out_sat,
    output logic             frame_drop
);

    localparam int SHIFT = 16 - OUT_FRAC;
    localparam logic signed [32:0] MAX_V = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
    localparam logic signed [32:0] MIN_V = -(33'sd1 <<< (OUT_W - 1));
    // Half an output LSB; collapses to zero when no bits are shifted out.
    localparam logic [32:0] RND = (33'd1 << SHIFT) >> 1;

    typedef enum logic {IDLE, STREAM} rd_state_t;

    // Each entry is {sat, data}; contents survive reset.
    logic [OUT_W:0] mem [0:1][0:15];

    logic [3:0]  wcnt;
    logic        wbank;
    logic        keep;
    logic [1:0]  full, full_n;
    logic        bank_free, wr_en, wr_done;

    rd_state_t   state, state_n;
    logic [3:0]  rcnt, rcnt_n;
    logic        rbank, rbank_n;
    logic        rel;
    logic        ld_en, ld_bank;
    logic [3:0]  ld_addr;
    logic [OUT_W:0] ld_word;
    logic             out_valid_n, out_last_n, out_sat_n;
    logic [OUT_W-1:0] out_data_n;
    logic [3:0]       out_index_n;

    logic signed [32:0] ext, shifted;
    logic [OUT_W:0]     conv;

    always_comb begin
        ext = {in_data[31], in_data};
`ifdef GSIM_COLLECT_ROUND_EN
        ext = ext + $signed(RND);
`endif
        shifted = ext >>> SHIFT;
        if (shifted > MAX_V)
            conv = {1'b1, MAX_V[OUT_W-1:0]};
        else if (shifted < MIN_V)
            conv = {1'b1, MIN_V[OUT_W-1:0]};
        else
            conv = {1'b0, shifted[OUT_W-1:0]};
    end

    // A bank being released on this very edge counts as free for a new frame.
    assign bank_free = !full[wbank] || (rel && (rbank == wbank));
    assign wr_en     = in_valid && ((wcnt == 4'd0) ? bank_free : keep);
    assign wr_done   = wr_en && (wcnt == 4'd15);

    always_comb begin
        full_n = full;
        if (rel)     full_n[rbank] = 1'b0;
        if (wr_done) full_n[wbank] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt       <= '0;
            wbank      <= 1'b0;
            keep       <= 1'b0;
            full       <= '0;
            frame_drop <= 1'b0;
        end else begin
            full       <= full_n;
            frame_drop <= in_valid && (wcnt == 4'd0) && !bank_free;
            if (in_valid) begin
                wcnt <= wcnt + 4'd1;
                if (wcnt == 4'd0) keep <= bank_free;
            end
            if (wr_done) wbank <= ~wbank;
        end
    end

    // Word k lands at natural index 4*(k mod 4) + k/4.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wbank][{wcnt[1:0], wcnt[3:2]}] <= conv;
    end

    assign ld_word = mem[ld_bank][ld_addr];

    always_comb begin
        state_n     = state;
        rcnt_n      = rcnt;
        rbank_n     = rbank;
        rel         = 1'b0;
        ld_en       = 1'b0;
        ld_bank     = rbank;
        ld_addr     = 4'd0;
        out_valid_n = out_valid;
        out_data_n  = out_data;
        out_index_n = out_index;
        out_last_n  = out_last;
        out_sat_n   = out_sat;
        case (state)
            IDLE: begin
                if (full[rbank]) begin
                    state_n = STREAM;
                    ld_en   = 1'b1;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (rcnt == 4'd15) begin
                        rel     = 1'b1;
                        rbank_n = ~rbank;
                        if (full[~rbank]) begin
                            ld_en   = 1'b1;
                            ld_bank = ~rbank;
                        end else begin
                            state_n     = IDLE;
                            out_valid_n = 1'b0;
                            out_last_n  = 1'b0;
                        end
                    end else begin
                        ld_en   = 1'b1;
                        ld_addr = rcnt + 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (ld_en) begin
            rcnt_n      = ld_addr;
            out_valid_n = 1'b1;
            out_data_n  = ld_word[OUT_W-1:0];
            out_sat_n   = ld_word[OUT_W];
            out_index_n = ld_addr;
            out_last_n  = (ld_addr == 4'd15);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rcnt      <= '0;
            rbank     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            state     <= state_n;
            rcnt      <= rcnt_n;
            rbank     <= rbank_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            out_index <= out_index_n;
            out_last  <= out_last_n;
            out_sat   <= out_sat_n;
        end
    end

endmodule

// File: tb/tb_gsim_result_collector.sv
// Directed bench for gsim_result_collector: reorder, conversion, ping-pong/drop, backpressure and reset.
module tb_gsim_result_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_index;
    logic        out_last;
    logic        out_sat;
    logic        frame_drop;

    gsim_result_collector #(.OUT_W(16), .OUT_FRAC(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .out_sat(out_sat),
        .frame_drop(frame_drop)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int drop_cnt = 0;
    int drop_cyc = -1;
    int start_cyc = 0;
    logic [31:0] fw [16];
    logic [15:0] q_data [$];
    int          q_idx  [$];
    int          q_last [$];
    int          q_sat  [$];
    int          q_cyc  [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int tk(input int i);
        return 4 * (i % 4) + i / 4;
    endfunction

    // Handshake recorder, drop counter and stall-hold checker.
    initial begin : mon
        logic        stall;
        logic [22:0] held;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(posedge clk);
            if (!reset) begin
                if (stall) chk("hold", {9'd0, out_valid, out_index, out_last, out_sat, out_data}, {9'd0, held});
                if (out_valid && out_ready) begin
                    q_data.push_back(out_data);
                    q_idx.push_back(int'(out_index));
                    q_last.push_back(int'(out_last));
                    q_sat.push_back(int'(out_sat));
                    q_cyc.push_back(cyc);
                end
                if (frame_drop) begin
                    drop_cnt++;
                    drop_cyc = cyc;
                end
                stall = out_valid && !out_ready;
                held  = {out_valid, out_index, out_last, out_sat, out_data};
            end else begin
                stall = 1'b0;
            end
            cyc++;
        end
    end

    task automatic qclear();
        q_data.delete(); q_idx.delete(); q_last.delete(); q_sat.delete(); q_cyc.delete();
    endtask

    task automatic send();
        start_cyc = cyc;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_data  = fw[k];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_n(input int n);
        int t;
        t = 0;
        while (q_data.size() < n && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("word_count", q_data.size(), n);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"},  out_data, 0);
        chk({tag, "_index"}, out_index, 0);
        chk({tag, "_last"},  out_last, 0);
        chk({tag, "_sat"},   out_sat, 0);
        chk({tag, "_drop"},  frame_drop, 0);
    endtask

    initial begin : stim
        int lasts;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #12;
        chk_zero_outputs("rst");
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // Reorder and latency.
        for (int k = 0; k < 16; k++) fw[k] = k << 16;
        qclear();
        send();
        chk("lat_early", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_valid", out_valid, 1);
        chk("lat_index", out_index, 0);
        wait_n(16);
        for (int i = 0; i < q_data.size() && i < 16; i++) begin
            chk("reo_idx",  q_idx[i], i);
            chk("reo_data", q_data[i], tk(i) << 8);
            chk("reo_last", q_last[i], (i == 15) ? 1 : 0);
        end
        repeat (4) begin @(posedge clk); #1; end
        chk("reo_total", q_data.size(), 16);

        // Saturation and rounding (k=0,1,2,3,4 -> index 0,4,8,12,1).
        for (int k = 0; k < 16; k++) fw[k] = '0;
        fw[0] = 32'h0080_0000; fw[1] = 32'hFF7F_0000; fw[2] = 32'h007F_FF00;
        fw[3] = 32'h0000_0080; fw[4] = 32'hFFFF_FF80;
        qclear();
        send();
        wait_n(16);
        if (q_data.size() == 16) begin
            chk("sat_pos",     q_data[0], 16'h7FFF);
            chk("sat_pos_f",   q_sat[0], 1);
            chk("sat_neg",     q_data[4], 16'h8000);
            chk("sat_neg_f",   q_sat[4], 1);
            chk("nosat_max",   q_data[8], 16'h7FFF);
            chk("nosat_max_f", q_sat[8], 0);
`ifdef GSIM_COLLECT_ROUND_EN
            chk("rnd_pos", q_data[12], 16'h0001);
            chk("rnd_neg", q_data[1], 16'h0000);
`else
            chk("rnd_pos", q_data[12], 16'h0000);
            chk("rnd_neg", q_data[1], 16'hFFFF);
`endif
            chk("rnd_sat_f", q_sat[12], 0);
        end

        // Ping-pong fill with the consumer stalled, third frame dropped.
        out_ready = 1'b0;
        qclear();
        drop_cnt = 0;
        begin
            int s3;
            s3 = 0;
            for (int f = 0; f < 3; f++) begin
                for (int k = 0; k < 16; k++) fw[k] = (16 * f + k) << 16;
                if (f == 2) s3 = cyc;
                send();
            end
            repeat (3) begin @(posedge clk); #1; end
            chk("drop_cnt", drop_cnt, 1);
            chk("drop_cyc", drop_cyc, s3 + 1);
        end
        chk("stall_valid", out_valid, 1);
        chk("stall_none",  q_data.size(), 0);
        out_ready = 1'b1;
        wait_n(32);
        lasts = 0;
        for (int j = 0; j < q_data.size() && j < 32; j++) begin
            chk("pp_idx",  q_idx[j], j % 16);
            chk("pp_data", q_data[j], (16 * (j / 16) + tk(j % 16)) << 8);
            lasts += q_last[j];
        end
        chk("pp_lasts", lasts, 2);
        if (q_cyc.size() >= 32) chk("pp_nobubble", q_cyc[31] - q_cyc[0], 31);
        repeat (20) begin @(posedge clk); #1; end
        chk("pp_total", q_data.size(), 32);

        // Backpressure: out_ready alternates every cycle.
        for (int k = 0; k < 16; k++) fw[k] = (k + 16) << 16;
        qclear();
        fork
            send();
            begin
                int t;
                t = 0;
                while (q_data.size() < 16 && t < 300) begin
                    out_ready = ~out_ready;
                    @(posedge clk); #1;
                    t++;
                end
            end
        join
        out_ready = 1'b1;
        wait_n(16);
        for (int i = 0; i < q_data.size() && i < 16; i++) begin
            chk("bp_idx",  q_idx[i], i);
            chk("bp_data", q_data[i], (16 + tk(i)) << 8);
        end
        repeat (5) begin @(posedge clk); #1; end
        chk("bp_total", q_data.size(), 16);

        // Asynchronous reset mid-stream, then a clean frame.
        for (int k = 0; k < 16; k++) fw[k] = k << 16;
        qclear();
        send();
        wait_n(5);
        #3;
        reset = 1'b1;
        #1;
        chk_zero_outputs("mid_rst");
        @(posedge clk); #1;
        reset = 1'b0;
        qclear();
        for (int k = 0; k < 16; k++) fw[k] = (k + 32) << 16;
        send();
        wait_n(16);
        for (int i = 0; i < q_data.size() && i < 16; i++) begin
            chk("post_idx",  q_idx[i], i);
            chk("post_data", q_data[i], (32 + tk(i)) << 8);
        end
        repeat (5) begin @(posedge clk); #1; end
        chk("post_total", q_data.size(), 16);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : guard
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
